// File: rtl/uart_tx_arb_if.sv
// Source-side byte streams and uart_tx handshake shared by the packet arbiter.
interface uart_tx_arb_if #(
    parameter int unsigned N_REQ = 3
);
    logic [N_REQ-1:0]   s_valid;
    logic [8*N_REQ-1:0] s_data;
    logic [N_REQ-1:0]   s_last;
    logic [N_REQ-1:0]   s_ready;
    logic [N_REQ-1:0]   grant;
    logic               tx_en;
    logic [7:0]         tx_data;
    logic               tx_done;
    logic               busy;

    // Sources and the uart_tx model drive this side.
    modport master (
        output s_valid, s_data, s_last, tx_done,
        input  s_ready, grant, tx_en, tx_data, busy
    );

    // The arbiter sits on this side.
    modport slave (
        input  s_valid, s_data, s_last, tx_done,
        output s_ready, grant, tx_en, tx_data, busy
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter in front of a single uart_tx byte transmitter.
// A source keeps the transmitter from its first byte until its last byte completes,
// or until it leaves s_valid low for TIMEOUT cycles while waiting for its next byte.
module uart_tx_arb #(
    parameter int unsigned N_REQ   = 3,
    parameter logic [15:0] GAP_CYC = 16'd0,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_tx_arb_if.slave bus
);
    localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StGap} state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_en_q, tx_en_d;
    logic               last_q, last_d;
    logic [15:0]        cnt_q, cnt_d;

    logic [OW-1:0]      rr_start;
    logic [2*N_REQ-1:0] rr_dup;
    logic [N_REQ-1:0]   rr_rot;
    logic [OW-1:0]      rr_off;
    logic [OW:0]        rr_sum;
    logic               win_found;
    logic [OW-1:0]      win_idx;
    logic [N_REQ-1:0]   ready;
    logic               hs;
    logic [7:0]         sel_data;
    logic               sel_last;

    // Round-robin pick: rotate requests so the slot after the last owner is bit 0.
    always_comb begin
        rr_start  = owner_q + OW'(1);
        rr_dup    = {bus.s_valid, bus.s_valid} >> rr_start;
        rr_rot    = rr_dup[N_REQ-1:0];
        rr_off    = '0;
        win_found = |rr_rot;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rr_rot[i]) begin
                rr_off = OW'(i);
            end
        end
        rr_sum = {1'b0, rr_start} + {1'b0, rr_off};
        if (rr_sum >= (OW + 1)'(N_REQ)) begin
            rr_sum = rr_sum - (OW + 1)'(N_REQ);
        end
        win_idx = rr_sum[OW-1:0];
    end

    // Byte and last flag of the current owner, plus the one-hot accept.
    always_comb begin
        sel_data = 8'h00;
        sel_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                sel_data = bus.s_data[8*i +: 8];
                sel_last = bus.s_last[i];
            end
        end
        ready = grant_q & bus.s_valid & {N_REQ{state_q == StLoad}};
        hs    = |ready;
    end

    // Next-state logic; the timeout and gap counters share cnt_q and saturate.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        last_d    = last_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    grant_d = N_REQ'(1) << win_idx;
                    owner_d = win_idx;
                    cnt_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (hs) begin
                    tx_data_d = sel_data;
                    last_d    = sel_last;
                    tx_en_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = StSend;
                end else if (cnt_q == TIMEOUT - 16'd1) begin
                    // owner_q keeps the stalled source so the next pick skips it.
                    grant_d = '0;
                    state_d = StIdle;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StSend: begin
                if (bus.tx_done) begin
                    cnt_d = '0;
                    if (last_q) begin
                        grant_d = '0;
                        state_d = (GAP_CYC == 16'd0) ? StIdle : StGap;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StGap: begin
                if (cnt_q >= GAP_CYC - 16'd1) begin
                    state_d = StIdle;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register; reset makes requester 0 the first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            owner_q   <= OW'(N_REQ - 1);
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.s_ready = ready;
    assign bus.grant   = grant_q;
    assign bus.tx_en   = tx_en_q;
    assign bus.tx_data = tx_data_q;
    assign bus.busy    = (state_q != StIdle);
endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Packet-level round-robin arbiter that shares the single `uart_tx` byte transmitter between several message sources, such as the RTC date/time reporter, an alarm reporter and a debug dump. Each source streams bytes over a valid/ready handshake and marks its final byte with `last`. The arbiter locks the transmitter to one source for a whole packet, so message bytes never interleave. It sits between the sources and `uart_tx`: it drives `tx_en`/`tx_data` and consumes `tx_done`.

## Interface
- `N_REQ`, 3: number of requesters, legal range 2..8.
- `GAP_CYC`, 16'd0: idle clk cycles inserted after each packet; 0 means no gap.
- `TIMEOUT`, 16'd50000: clk cycles a locked source may leave `s_valid` low before the lock is dropped.

Ports:
- `clk`, in, 1: system clock, 50 MHz.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `s_valid`, in, N_REQ: per-source byte valid.
- `s_data`, in, 8*N_REQ: per-source byte; source i uses bits [8i+7:8i].
- `s_last`, in, N_REQ: per-source flag marking the final byte of a packet.
- `s_ready`, out, N_REQ: per-source byte accept; one-hot or zero.
- `grant`, out, N_REQ: one-hot owner of the transmitter; zero when unowned.
- `tx_en`, out, 1: one-cycle start pulse to `uart_tx`.
- `tx_data`, out, 8: byte sent to `uart_tx`; held from `tx_en` until `tx_done`.
- `tx_done`, in, 1: one-cycle frame-complete pulse from `uart_tx`.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- States: IDLE, LOAD, SEND, GAP.
- **IDLE**
  - If any `s_valid` is high, pick the winner by round robin, starting from (`last_owner`+1) mod N_REQ.
  - Register the winner into `grant` and `last_owner`, then go to LOAD.
  - Only `s_valid` is used for the decision; `s_last` is ignored here.
- **LOAD**
  - `s_ready[i]` = `grant[i]` & `s_valid[i]` & (state==LOAD). This is combinational.
  - On a handshake: `tx_data` <= byte, `last_r` <= `s_last[i]`, `tx_en` <= 1 for exactly one cycle, timeout counter cleared, go to SEND.
  - Without a handshake: the timeout counter increments. When it reaches TIMEOUT-1, `grant` is cleared and the state returns to IDLE with no further bytes accepted. `last_owner` keeps the timed-out source, so round robin moves past it.
- **SEND**
  - Wait for `tx_done`.
  - On `tx_done` with `last_r`=0: go to LOAD with the same grant.
  - On `tx_done` with `last_r`=1: clear `grant`, then go to GAP, or to IDLE if GAP_CYC=0.
- **GAP**
  - The gap counter counts up to GAP_CYC-1, then the state goes to IDLE.
- Requests arriving during SEND or GAP only take effect after the return to IDLE.
- `tx_done` seen outside SEND is ignored.
- `s_valid` from non-granted sources is ignored; their `s_ready` stays 0.
- The timeout and gap counters are 16 bits wide and saturate; they never wrap.
- Single-byte packet (`s_last` on the first byte): LOAD → SEND → GAP/IDLE.

## Timing
- Reset values:
  - `grant`=0, `s_ready`=0, `tx_en`=0, `tx_data`=8'h00, `busy`=0, state IDLE.
  - `last_owner`=N_REQ-1, so requester 0 wins first after reset.
- Latency:
  - `s_valid` seen in IDLE at cycle n gives `grant` high at n+1, `s_ready` at n+1 (LOAD), and `tx_en` at n+2.
  - Between bytes: `tx_done` at cycle m leads to LOAD at m+1. With `s_valid` already high, `s_ready` is at m+1 and `tx_en` at m+2.
- `tx_data` is stable from the `tx_en` cycle through the `tx_done` cycle.
- Reset asserted mid-packet returns every output to its reset value immediately; the partially sent packet is abandoned.

## Test plan
- **Single source:** source 0 sends a 3-byte packet 8'h32, 8'h30, 8'h0A (last).
  - Exactly 3 `tx_en` pulses with `tx_data` in that order.
  - `grant` = 3'b001 throughout; `grant` = 0 after the final `tx_done`.
- **Round robin:** all three sources request continuously with 2-byte packets.
  - Owner order is 0, 1, 2, 0.
  - No byte from another source appears inside a packet.
- **Latency:** `s_valid[1]` rises at cycle 10 in IDLE.
  - `grant` = 3'b010 at cycle 11, `s_ready[1]` at 11, `tx_en` at 12.
  - Model `tx_done` returning 20 cycles after `tx_en`; the next `tx_en` follows 2 cycles after that `tx_done`.
- **Timeout and gap:** TIMEOUT=100; source 2 drops `s_valid` after its first byte.
  - `grant` clears 100 cycles after entering LOAD; the next winner is source 0.
  - With GAP_CYC=5, `busy` stays high for 5 cycles after a `last` byte's `tx_done`.
- **Reset and spurious done:** assert `rst_n`=0 during SEND.
  - All outputs are 0 in the same cycle.
  - After release, source 0 wins first.
  - A `tx_done` pulse injected while in IDLE causes no state change.
